// File: rtl/count_sequence_checker.sv
// Sequence monitor for the lab down-counters: checks binary-down or Johnson-down transitions,
// counts errors and wraps, and flags a counter whose divided clock has stopped.
module count_sequence_checker #(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned ERR_W        = 8,
    parameter int unsigned WRAP_W       = 8,
    parameter int unsigned STALL_CYCLES = 100000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              count_clk,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              mode,
    input  logic              clear,
    output logic              locked,
    output logic              err_pulse,
    output logic              err_sticky,
    output logic              stall,
    output logic [ERR_W-1:0]  err_count,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [WIDTH-1:0]  last_count
);

    localparam int unsigned TW = $clog2(STALL_CYCLES + 1);

    typedef enum logic [1:0] {StAcquire, StLocked, StStalled} state_e;

    state_e              state_q, state_d;
    logic                cc_meta_q, cc_sync_q, cc_dly_q, mode_q;
    logic [WIDTH-1:0]    prev_q;
    logic [TW-1:0]       timer_q, timer_d;
    logic                locked_q, locked_d, stall_q, stall_d;
    logic                err_pulse_q, err_sticky_q;
    logic [ERR_W-1:0]    err_count_q;
    logic [WRAP_W-1:0]   wrap_count_q;
    logic [WIDTH-1:0]    last_count_q;

    logic                sample_evt, mode_chg, stall_reach, acquire_like;
    logic                jc_valid, bad_code, wrap_hit;
    logic                err_evt, wrap_evt, accept;
    logic [WIDTH-1:0]    exp_val;
    logic [WIDTH-2:0]    edges;

    always_comb begin
        sample_evt = cc_sync_q & ~cc_dly_q;
        mode_chg   = mode ^ mode_q;
        exp_val    = mode ? {~prev_q[0], prev_q[WIDTH-1:1]} : prev_q - WIDTH'(1);
        for (int i = 0; i < WIDTH - 1; i++) begin
            edges[i] = count_in[i+1] ^ count_in[i];
        end
        // Johnson codes have at most one boundary between a run of ones and a run of zeros
        jc_valid     = (edges & (edges - (WIDTH-1)'(1))) == '0;
        bad_code     = mode & ~jc_valid;
        wrap_hit     = mode ? (prev_q == WIDTH'(1) && count_in == '0)
                            : (prev_q == '0 && count_in == '1);
        acquire_like = (state_q != StLocked) || mode_chg;
        stall_reach  = !sample_evt && (timer_q == TW'(STALL_CYCLES - 1));

        if (sample_evt) begin
            timer_d = '0;
        end else if (timer_q == TW'(STALL_CYCLES)) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + TW'(1);
        end

        err_evt  = 1'b0;
        wrap_evt = 1'b0;
        accept   = 1'b0;
        state_d  = state_q;
        locked_d = locked_q;
        stall_d  = stall_q;
        if (sample_evt) begin
            stall_d = 1'b0;
            if (bad_code) begin
                err_evt  = 1'b1;
                state_d  = StAcquire;
                locked_d = 1'b0;
            end else if (acquire_like) begin
                accept   = 1'b1;
                state_d  = StLocked;
                locked_d = 1'b1;
            end else begin
                accept   = 1'b1;
                err_evt  = (count_in != exp_val);
                wrap_evt = (count_in == exp_val) && wrap_hit;
            end
        end else if (stall_reach) begin
            state_d  = StStalled;
            stall_d  = 1'b1;
            locked_d = 1'b0;
        end else if (mode_chg) begin
            state_d  = StAcquire;
            locked_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StAcquire;
            cc_meta_q    <= 1'b0;
            cc_sync_q    <= 1'b0;
            cc_dly_q     <= 1'b0;
            mode_q       <= 1'b0;
            prev_q       <= '0;
            timer_q      <= '0;
            locked_q     <= 1'b0;
            stall_q      <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
            wrap_count_q <= '0;
            last_count_q <= '0;
        end else begin
            cc_meta_q   <= count_clk;
            cc_sync_q   <= cc_meta_q;
            cc_dly_q    <= cc_sync_q;
            mode_q      <= mode;
            state_q     <= state_d;
            timer_q     <= timer_d;
            locked_q    <= locked_d;
            stall_q     <= stall_d;
            err_pulse_q <= err_evt;
            if (sample_evt) begin
                last_count_q <= count_in;
            end
            if (accept) begin
                prev_q <= count_in;
            end
            // clear beats any same-cycle increment; the pulse above is still emitted
            if (clear) begin
                err_sticky_q <= 1'b0;
                err_count_q  <= '0;
                wrap_count_q <= '0;
            end else begin
                if (err_evt) begin
                    err_sticky_q <= 1'b1;
                    if (err_count_q != '1) begin
                        err_count_q <= err_count_q + ERR_W'(1);
                    end
                end
                if (wrap_evt) begin
                    wrap_count_q <= wrap_count_q + WRAP_W'(1);
                end
            end
        end
    end

    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign err_sticky = err_sticky_q;
    assign stall      = stall_q;
    assign err_count  = err_count_q;
    assign wrap_count = wrap_count_q;
    assign last_count = last_count_q;

endmodule
